subneg_ctrl: RTL and testbench

- Sequencer for the SUBNEG one-instruction processor.
- Fetches a three-word instruction (A, B, C) from a single-port synchronous memory and drives the combinational `sub` datapath with mem[A] and mem[B].
- Writes mem[B] − mem[A] back to mem[B]. Branches to C when the result is negative, otherwise falls through to PC+3.
- Sits between the program/data memory and the `sub` instance; the `sub` block itself stays outside this module.

---
 rtl/subneg_ctrl.sv | 174 +++++++++++++++++
 tb/tb_subneg_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subneg_ctrl.sv
// subneg_ctrl: instruction sequencer for the SUBNEG one-instruction machine.
// Fetches A, B, C from a single-port synchronous memory, reads mem[A] and
// mem[B], presents them to an external `sub` block, writes mem[B]-mem[A]
// back to mem[B] and branches to C when the result is negative.
module subneg_ctrl #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              mem_wr_en,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [WIDTH-1:0]  sub_in1,
  output logic [WIDTH-1:0]  sub_in2,
  input  logic [WIDTH-1:0]  sub_out,
  input  logic              sub_neg,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FA,
    S_FB,
    S_FC,
    S_RDA,
    S_RDB,
    S_LATCH,
    S_WB,
    S_HALT
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_c;
  logic [WIDTH-1:0]   r_opA;
  logic [WIDTH-1:0]   r_opB;
  logic [WIDTH-1:0]   r_hold1;
  logic [WIDTH-1:0]   r_hold2;
  logic               w_halt;

  // Self-loop branch (C equals the current instruction address) stops the machine
  assign w_halt = sub_neg && (r_c[ADDR_W-1:0] == r_pc);

  // Sequencer: walks the seven-cycle fetch/read/write-back pattern and
  // captures each returned memory word one cycle after its read strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_opA   <= '0;
      r_opB   <= '0;
      r_hold1 <= '0;
      r_hold2 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc    <= start_pc;
            r_state <= S_FA;
          end
        end
        S_FA:    r_state <= S_FB;
        S_FB: begin
          r_a     <= mem_rdata;
          r_state <= S_FC;
        end
        S_FC: begin
          r_b     <= mem_rdata;
          r_state <= S_RDA;
        end
        S_RDA: begin
          r_c     <= mem_rdata;
          r_state <= S_RDB;
        end
        S_RDB: begin
          r_opA   <= mem_rdata;
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_opB   <= mem_rdata;
          r_state <= S_WB;
        end
        S_WB: begin
          r_hold1 <= r_opA;
          r_hold2 <= r_opB;
          if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (w_halt) begin
            r_state <= S_HALT;
          end else if (sub_neg) begin
            r_pc    <= r_c[ADDR_W-1:0];
            r_state <= S_FA;
          end else begin
            r_pc    <= r_pc + ADDR_W'(3);
            r_state <= S_FA;
          end
        end
        S_HALT: begin
          if (start) begin
            r_pc    <= start_pc;
            r_cnt   <= '0;
            r_state <= S_FA;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory strobes and address decoded from the current state; reads and
  // writes live in disjoint states so they can never overlap
  always_comb begin
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    case (r_state)
      S_FA: begin
        mem_addr  = r_pc;
        mem_rd_en = 1'b1;
      end
      S_FB: begin
        mem_addr  = r_pc + ADDR_W'(1);
        mem_rd_en = 1'b1;
      end
      S_FC: begin
        mem_addr  = r_pc + ADDR_W'(2);
        mem_rd_en = 1'b1;
      end
      S_RDA: begin
        mem_addr  = r_a[ADDR_W-1:0];
        mem_rd_en = 1'b1;
      end
      S_RDB: begin
        mem_addr  = r_b[ADDR_W-1:0];
        mem_rd_en = 1'b1;
      end
      S_WB: begin
        mem_addr  = r_b[ADDR_W-1:0];
        mem_wr_en = 1'b1;
        mem_wdata = sub_out;
      end
      default: begin
        mem_addr  = '0;
      end
    endcase
  end

  // Operands go live in write-back and otherwise show the last pair used
  assign sub_in1     = (r_state == S_WB) ? r_opA : r_hold1;
  assign sub_in2     = (r_state == S_WB) ? r_opB : r_hold2;
  assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted      = (r_state == S_HALT);
  assign pc          = r_pc;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_subneg_ctrl.sv
// tb_subneg_ctrl: directed scoreboard bench for subneg_ctrl with a behavioural
// synchronous memory and the external `sub` datapath modelled alongside.
module tb_subneg_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  start_pc;
  logic [7:0]  mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rdata;
  logic        mem_wr_en;
  logic [7:0]  mem_wdata;
  logic [7:0]  sub_in1;
  logic [7:0]  sub_in2;
  logic [7:0]  sub_out;
  logic        sub_neg;
  logic        busy;
  logic        halted;
  logic [7:0]  pc;
  logic [15:0] instr_count;

  logic [7:0]  mem [0:255];
  logic        tbLoad;
  logic [7:0]  tbAddr;
  logic [7:0]  tbData;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       neg;
    logic [7:0] nextPc;
  } wr_t;

  wr_t  expQ[$];
  int   total;
  int   bad;
  logic pcPending;
  logic [7:0] pendPc;

  subneg_ctrl #(.WIDTH(8), .ADDR_W(8), .CNT_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .start_pc(start_pc),
    .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata),
    .sub_in1(sub_in1),
    .sub_in2(sub_in2),
    .sub_out(sub_out),
    .sub_neg(sub_neg),
    .busy(busy),
    .halted(halted),
    .pc(pc),
    .instr_count(instr_count)
  );

  // External subtractor: in2 - in1, wrapped, sign bit as the negative flag
  assign sub_out = sub_in2 - sub_in1;
  assign sub_neg = sub_out[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory with a bench-side preload port
  always @(posedge clk) begin
    if (tbLoad) begin
      mem[tbAddr] <= tbData;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic loadWord(input logic [7:0] a, input logic [7:0] d);
    tbLoad = 1'b1;
    tbAddr = a;
    tbData = d;
    tick(1);
    tbLoad = 1'b0;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) begin
      loadWord(8'(i), 8'h00);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] spc);
    start_pc = spc;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
  endtask

  task automatic waitHalted(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput("halt-timeout", {31'd0, halted}, 32'd1);
  endtask

  // Write monitor: every write strobe is matched against the scoreboard and
  // the following cycle's pc is checked against the predicted branch target
  always @(negedge clk) begin
    wr_t e;
    if (pcPending) begin
      checkOutput("wb-next-pc", {24'd0, pc}, {24'd0, pendPc});
      pcPending = 1'b0;
    end
    if (mem_wr_en) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected-write: got addr=%0h data=%0h expected no write", mem_addr, mem_wdata);
      end else begin
        e = expQ.pop_front();
        checkOutput("wb-addr", {24'd0, mem_addr}, {24'd0, e.addr});
        checkOutput("wb-data", {24'd0, mem_wdata}, {24'd0, e.data});
        checkOutput("wb-neg", {31'd0, sub_neg}, {31'd0, e.neg});
        checkOutput("wb-no-read", {31'd0, mem_rd_en}, 32'd0);
        pendPc    = e.nextPc;
        pcPending = 1'b1;
      end
    end
  end

  // Watchdog against a stuck run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios
  initial begin
    total     = 0;
    bad       = 0;
    pcPending = 1'b0;
    pendPc    = '0;
    tbLoad    = 1'b0;
    tbAddr    = '0;
    tbData    = '0;
    rst_n     = 1'b0;
    start     = 1'b1;
    start_pc  = 8'd0;

    // Reset held with start asserted
    tick(3);
    checkOutput("rst-addr", {24'd0, mem_addr}, 32'd0);
    checkOutput("rst-rd", {31'd0, mem_rd_en}, 32'd0);
    checkOutput("rst-wr", {31'd0, mem_wr_en}, 32'd0);
    checkOutput("rst-wdata", {24'd0, mem_wdata}, 32'd0);
    checkOutput("rst-busy", {31'd0, busy}, 32'd0);
    checkOutput("rst-halted", {31'd0, halted}, 32'd0);
    checkOutput("rst-pc", {24'd0, pc}, 32'd0);
    checkOutput("rst-count", {16'd0, instr_count}, 32'd0);
    checkOutput("rst-in1", {24'd0, sub_in1}, 32'd0);
    checkOutput("rst-in2", {24'd0, sub_in2}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick(3);
    checkOutput("idle-busy", {31'd0, busy}, 32'd0);

    // Fall-through: 5 - 3 = 2
    rst_n = 1'b0;
    clearMem();
    loadWord(8'd0, 8'd10); loadWord(8'd1, 8'd11); loadWord(8'd2, 8'd20);
    loadWord(8'd10, 8'd3); loadWord(8'd11, 8'd5);
    rst_n = 1'b1;
    tick(1);
    expQ.push_back('{8'd11, 8'd2, 1'b0, 8'd3});
    applyStimulus(8'd0);
    checkOutput("ft-fa-addr", {24'd0, mem_addr}, 32'd0);
    checkOutput("ft-fa-rd", {31'd0, mem_rd_en}, 32'd1);
    checkOutput("ft-busy", {31'd0, busy}, 32'd1);
    tick(6);
    checkOutput("ft-c7-wr", {31'd0, mem_wr_en}, 32'd1);
    checkOutput("ft-c7-addr", {24'd0, mem_addr}, 32'd11);
    checkOutput("ft-c7-in1", {24'd0, sub_in1}, 32'd3);
    checkOutput("ft-c7-in2", {24'd0, sub_in2}, 32'd5);
    tick(1);
    checkOutput("ft-pc", {24'd0, pc}, 32'd3);
    checkOutput("ft-count", {16'd0, instr_count}, 32'd1);
    checkOutput("ft-next-addr", {24'd0, mem_addr}, 32'd3);
    checkOutput("ft-hold-in1", {24'd0, sub_in1}, 32'd3);

    // Branch taken: 3 - 5 = 0xFE
    rst_n = 1'b0;
    clearMem();
    loadWord(8'd0, 8'd10); loadWord(8'd1, 8'd11); loadWord(8'd2, 8'd20);
    loadWord(8'd10, 8'd5); loadWord(8'd11, 8'd3);
    rst_n = 1'b1;
    tick(1);
    expQ.push_back('{8'd11, 8'hFE, 1'b1, 8'd20});
    applyStimulus(8'd0);
    tick(7);
    checkOutput("br-next-addr", {24'd0, mem_addr}, 32'd20);

    // Halt on self-branch: 0 - 1 = 0xFF, C == pc
    rst_n = 1'b0;
    clearMem();
    loadWord(8'd20, 8'd30); loadWord(8'd21, 8'd31); loadWord(8'd22, 8'd20);
    loadWord(8'd30, 8'd1); loadWord(8'd31, 8'd0);
    rst_n = 1'b1;
    tick(1);
    expQ.push_back('{8'd31, 8'hFF, 1'b1, 8'd20});
    applyStimulus(8'd20);
    tick(7);
    checkOutput("halt-flag", {31'd0, halted}, 32'd1);
    checkOutput("halt-busy", {31'd0, busy}, 32'd0);
    checkOutput("halt-pc", {24'd0, pc}, 32'd20);
    checkOutput("halt-count", {16'd0, instr_count}, 32'd1);
    checkOutput("halt-rd", {31'd0, mem_rd_en}, 32'd0);
    // Restart from HALT: mem[31] is now 0xFF, 0xFF - 1 = 0xFE, halts again
    expQ.push_back('{8'd31, 8'hFE, 1'b1, 8'd20});
    applyStimulus(8'd20);
    checkOutput("restart-count", {16'd0, instr_count}, 32'd0);
    checkOutput("restart-busy", {31'd0, busy}, 32'd1);
    checkOutput("restart-addr", {24'd0, mem_addr}, 32'd20);
    waitHalted(20);
    checkOutput("restart-done-count", {16'd0, instr_count}, 32'd1);

    // Overflow and pc wrap: 0x80 - 1 = 0x7F, non-negative
    rst_n = 1'b0;
    clearMem();
    loadWord(8'd254, 8'd40); loadWord(8'd255, 8'd41); loadWord(8'd0, 8'd7);
    loadWord(8'd40, 8'd1); loadWord(8'd41, 8'h80);
    rst_n = 1'b1;
    tick(1);
    expQ.push_back('{8'd41, 8'h7F, 1'b0, 8'd1});
    applyStimulus(8'd254);
    checkOutput("wrap-fa", {24'd0, mem_addr}, 32'd254);
    tick(1);
    checkOutput("wrap-fb", {24'd0, mem_addr}, 32'd255);
    tick(1);
    checkOutput("wrap-fc", {24'd0, mem_addr}, 32'd0);
    tick(1);
    checkOutput("wrap-rda", {24'd0, mem_addr}, 32'd40);
    tick(5);
    checkOutput("wrap-pc", {24'd0, pc}, 32'd1);

    // Start pulse during RD_A is ignored
    rst_n = 1'b0;
    clearMem();
    loadWord(8'd0, 8'd10); loadWord(8'd1, 8'd11); loadWord(8'd2, 8'd20);
    loadWord(8'd10, 8'd3); loadWord(8'd11, 8'd5);
    rst_n = 1'b1;
    tick(1);
    expQ.push_back('{8'd11, 8'd2, 1'b0, 8'd3});
    applyStimulus(8'd0);
    tick(3);
    checkOutput("rob-rda-addr", {24'd0, mem_addr}, 32'd10);
    applyStimulus(8'd99);
    checkOutput("rob-pc", {24'd0, pc}, 32'd0);
    checkOutput("rob-rdb-addr", {24'd0, mem_addr}, 32'd11);
    tick(3);

    // Reset during LATCH aborts the write-back
    rst_n = 1'b0;
    clearMem();
    loadWord(8'd0, 8'd10); loadWord(8'd1, 8'd11); loadWord(8'd2, 8'd20);
    loadWord(8'd10, 8'd3); loadWord(8'd11, 8'd5);
    rst_n = 1'b1;
    tick(1);
    applyStimulus(8'd0);
    tick(5);
    checkOutput("abort-latch-rd", {31'd0, mem_rd_en}, 32'd0);
    rst_n = 1'b0;
    tick(1);
    checkOutput("abort-wr", {31'd0, mem_wr_en}, 32'd0);
    checkOutput("abort-busy", {31'd0, busy}, 32'd0);
    checkOutput("abort-count", {16'd0, instr_count}, 32'd0);
    checkOutput("abort-pc", {24'd0, pc}, 32'd0);
    tick(2);
    checkOutput("abort-mem", {24'd0, mem[11]}, 32'd5);
    rst_n = 1'b1;
    tick(3);
    checkOutput("abort-idle-busy", {31'd0, busy}, 32'd0);
    checkOutput("queue-empty", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
